// File: rtl/mem_arbiter_nport_if.sv
// Requester + RAM bundle for the N-port memory arbiter.
// slave = arbiter view, master = requester/RAM environment view.
interface mem_arbiter_nport_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req_Ren;
  logic [NUM_PORTS-1:0]        req_Wen;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_store;
  logic [NUM_PORTS*DATA_W-1:0] req_load;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_err;
  logic                        ramRen;
  logic                        ramWen;
  logic [ADDR_W-1:0]           ramaddr;
  logic [DATA_W-1:0]           ramstore;
  logic [DATA_W-1:0]           ramload;
  logic                        ram_busy;
  logic                        arb_busy;

  modport slave (
    input  req_Ren, req_Wen, req_addr, req_store, ramload, ram_busy,
    output req_load, req_ready, req_err, ramRen, ramWen, ramaddr, ramstore, arb_busy
  );

  modport master (
    output req_Ren, req_Wen, req_addr, req_store, ramload, ram_busy,
    input  req_load, req_ready, req_err, ramRen, ramWen, ramaddr, ramstore, arb_busy
  );
endinterface

// File: rtl/mem_arbiter_nport.sv
// N-port arbiter onto one single-ported RAM with bounded wait and timeout error.
// Define ROUND_ROBIN_EN for round-robin grant; otherwise fixed priority (port 0 highest).
module mem_arbiter_nport #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                CLK,
  input  logic                RST,
  mem_arbiter_nport_if.slave  bus
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                           r_state, w_next;
  logic [NUM_PORTS-1:0]             w_req;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_store;
  logic [NUM_PORTS-1:0][DATA_W-1:0] r_load;
  logic [PTR_W-1:0]                 w_win, r_win;
  logic                             r_wr, r_abort;
  logic [ADDR_W-1:0]                r_addr;
  logic [DATA_W-1:0]                r_store;
  logic [CNT_W-1:0]                 r_cnt;
  logic                             w_timeout;

  assign w_req    = bus.req_Ren | bus.req_Wen;
  assign w_addr   = bus.req_addr;
  assign w_store  = bus.req_store;
  assign bus.req_load = r_load;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;

  // Abort on the TIMEOUT_CYC-th consecutive busy cycle in ACCESS.
  assign w_timeout = bus.ram_busy && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_rr;

  // Scan downward so the first requester at or after r_rr wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    w_win = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_w = PTR_W'(idx);
      if (w_req[idx_w]) w_win = idx_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                r_rr <= '0;
    else if (r_state == RESP)
      r_rr <= (r_win == PTR_W'(NUM_PORTS - 1)) ? '0 : r_win + 1'b1;
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (w_req[k]) w_win = PTR_W'(k);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.ramRen    = 1'b0;
    bus.ramWen    = 1'b0;
    bus.req_ready = '0;
    bus.req_err   = '0;
    bus.arb_busy  = (r_state != IDLE);
    case (r_state)
      IDLE:   if (|w_req) w_next = ACCESS;
      ACCESS: begin
        bus.ramRen = ~r_wr;
        bus.ramWen = r_wr;
        if (!bus.ram_busy || w_timeout) w_next = RESP;
      end
      RESP: begin
        bus.req_ready = NUM_PORTS'(1) << r_win;
        bus.req_err   = r_abort ? (NUM_PORTS'(1) << r_win) : '0;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Grant latch and wait counter; Ren+Wen on one port resolves to a write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_win   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_win   <= w_win;
          r_wr    <= bus.req_Wen[w_win];
          r_addr  <= w_addr[w_win];
          r_store <= w_store[w_win];
          r_cnt   <= '0;
          r_abort <= 1'b0;
        end
        ACCESS: begin
          if (w_timeout)         r_abort <= 1'b1;
          else if (bus.ram_busy) r_cnt   <= r_cnt + 1'b1;
        end
        RESP:    r_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_load <= '0;
    end else if (r_state == ACCESS && !bus.ram_busy && !r_wr) begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (r_win == PTR_W'(p)) r_load[p] <= bus.ramload;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Randomized bench for mem_arbiter_nport against a transaction-level reference model.
// Honours ROUND_ROBIN_EN the same way as the design.
module tb_mem_arbiter_nport;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_nport_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  mem_arbiter_nport #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: one transaction in flight, tracked by phase and busy cycles seen.
  typedef enum {M_IDLE, M_ACC, M_RESP} mph_t;
  mph_t          m_ph = M_IDLE;
  int            m_win = 0;
  int            m_rr = 0;
  int            m_busy = 0;
  bit            m_wr = 1'b0;
  bit            m_abort = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_load [N];

  // First requester at or after rr; fixed mode keeps rr at 0, i.e. lowest index.
  function automatic int arb_pick(input logic [N-1:0] req, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] req;
    int           w;
    req = bus.req_Ren | bus.req_Wen;
    if (RST) begin
      m_ph = M_IDLE;
      m_rr = 0;
      for (int p = 0; p < N; p++) m_load[p] = '0;
      return;
    end
    case (m_ph)
      M_IDLE: begin
        w = arb_pick(req, m_rr);
        if (w >= 0) begin
          m_win   = w;
          m_wr    = bus.req_Wen[w];
          m_addr  = bus.req_addr[w*AW +: AW];
          m_data  = bus.req_store[w*DW +: DW];
          m_busy  = 0;
          m_abort = 1'b0;
          m_ph    = M_ACC;
        end
      end
      M_ACC: begin
        if (!bus.ram_busy) begin
          if (!m_wr) m_load[m_win] = bus.ramload;
          m_ph = M_RESP;
        end else begin
          m_busy++;
          if (m_busy == TO) begin
            m_abort = 1'b1;
            m_ph    = M_RESP;
          end
        end
      end
      default: begin
`ifdef ROUND_ROBIN_EN
        m_rr = (m_win + 1) % N;
`endif
        m_ph = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [N-1:0] oh;
    oh = '0;
    if (m_ph == M_RESP) oh[m_win] = 1'b1;
    chk("arb_busy", bus.arb_busy, m_ph != M_IDLE);
    chk("ramRen", bus.ramRen, (m_ph == M_ACC) && !m_wr);
    chk("ramWen", bus.ramWen, (m_ph == M_ACC) && m_wr);
    if (m_ph == M_ACC) begin
      chk("ramaddr", bus.ramaddr, m_addr);
      if (m_wr) chk("ramstore", bus.ramstore, m_data);
    end
    chk("req_ready", bus.req_ready, oh);
    chk("req_err", bus.req_err, m_abort ? oh : '0);
    for (int p = 0; p < N; p++) chk("req_load", bus.req_load[p*DW +: DW], m_load[p]);
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_Ren[p]            = rd;
    bus.req_Wen[p]            = wr;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_store[p*DW +: DW] = d;
  endtask

  // Single request on port p; RAM busy for the first nbusy ACCESS cycles.
  task automatic txn(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int nbusy, input logic [DW-1:0] ld,
                     output int acc, output logic [N-1:0] rdy, output logic [N-1:0] err);
    set_req(p, !wr, wr, a, d);
    bus.ramload = ld;
    acc = 0;
    rdy = '0;
    err = '0;
    for (int c = 0; c < 40; c++) begin
      bus.ram_busy = (acc >= 1) && (acc <= nbusy);
      cyc();
      if (bus.ramRen || bus.ramWen) acc++;
      if (bus.req_ready != '0) begin
        rdy = bus.req_ready;
        err = bus.req_err;
        set_req(p, 1'b0, 1'b0, '0, '0);
        break;
      end
    end
    if (rdy == '0) chk("txn_no_ready", 1'b0, 1'b1);
    set_req(p, 1'b0, 1'b0, '0, '0);
    bus.ram_busy = 1'b0;
    cyc();
  endtask

  initial begin
    int            acc;
    logic [N-1:0]  rdy, err;
    int            grants;
    int            g;
    bus.req_Ren   = '0;
    bus.req_Wen   = '0;
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramload   = '0;
    bus.ram_busy  = 1'b0;
    RST = 1'b1;
    cyc();
    cyc();
    chk("rst_arb_busy", bus.arb_busy, 1'b0);
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_load", bus.req_load, '0);
    RST = 1'b0;
    cyc();

    // single read on port 1
    set_req(1, 1'b1, 1'b0, 32'h40, '0);
    bus.ramload = 32'hDEADBEEF;
    cyc();
    chk("rd_ramRen", bus.ramRen, 1'b1);
    chk("rd_ramaddr", bus.ramaddr, 32'h40);
    cyc();
    chk("rd_ready", bus.req_ready, 3'b010);
    chk("rd_load1", bus.req_load[DW +: DW], 32'hDEADBEEF);
    set_req(1, 1'b0, 1'b0, '0, '0);
    cyc();
    chk("rd_idle", bus.arb_busy, 1'b0);

    // write with two wait states
    txn(0, 1'b1, 32'h10, 32'h1234, 2, 32'h0, acc, rdy, err);
    chk("wr_cycles", acc, 3);
    chk("wr_ready", rdy, 3'b001);
    chk("wr_err", err, 3'b000);

    // seed port0 load, then time out and expect it unchanged
    txn(0, 1'b0, 32'h20, '0, 0, 32'hCAFEF00D, acc, rdy, err);
    chk("seed_load0", bus.req_load[0 +: DW], 32'hCAFEF00D);
    txn(0, 1'b0, 32'h24, '0, 100, 32'h55555555, acc, rdy, err);
    chk("to_cycles", acc, TO);
    chk("to_ready", rdy, 3'b001);
    chk("to_err", err, 3'b001);
    chk("to_load0", bus.req_load[0 +: DW], 32'hCAFEF00D);

    // reset while the RAM is stalling
    set_req(1, 1'b1, 1'b0, 32'h80, '0);
    bus.ram_busy = 1'b1;
    cyc();
    cyc();
    chk("mid_in_access", bus.ramRen, 1'b1);
    RST = 1'b1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    cyc();
    chk("mid_ramRen", bus.ramRen, 1'b0);
    chk("mid_arb_busy", bus.arb_busy, 1'b0);
    chk("mid_ready", bus.req_ready, '0);
    RST = 1'b0;
    bus.ram_busy = 1'b0;
    cyc();
    chk("mid_after_ready", bus.req_ready, '0);

    // all ports contend continuously
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 1'b0, 32'h100 + 32'(p), '0);
    grants = 0;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      bus.ramload = $urandom;
      cyc();
      if (bus.req_ready != '0) begin
        g = -1;
        for (int p = 0; p < N; p++) if (bus.req_ready[p]) g = p;
`ifdef ROUND_ROBIN_EN
        chk("cont_grant", g, grants % N);
`else
        chk("cont_grant", g, 0);
`endif
        grants++;
      end
    end
    chk("cont_count", grants, 6);
    for (int p = 0; p < N; p++) set_req(p, 1'b0, 1'b0, '0, '0);
    cyc();
    cyc();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!(bus.req_Ren[p] || bus.req_Wen[p]) && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       set_req(p, 1'b1, 1'b0, $urandom, $urandom);
            1:       set_req(p, 1'b0, 1'b1, $urandom, $urandom);
            default: set_req(p, 1'b1, 1'b1, $urandom, $urandom);
          endcase
        end
      end
      bus.ram_busy = 1'($urandom_range(0, 1));
      bus.ramload  = $urandom;
      if (m_ph == M_ACC && $urandom_range(0, 7) == 0) set_req(m_win, 1'b0, 1'b0, '0, '0);
      cyc();
      if (m_ph == M_RESP) set_req(m_win, 1'b0, 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
